// File: rtl/npc_pred_pkg.sv
// Shared next-PC op encodings plus the "does this op redirect fetch" helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package npc_pred_pkg;

    // Next-PC selector driven by decode and consumed in execute.
    typedef enum logic [1:0] {
        C_NPC_PC4  = 2'b00,
        C_NPC_JALR = 2'b01,
        C_NPC_B    = 2'b10,
        C_NPC_JAL  = 2'b11
    } npc_op_e;

    // True when the resolved instruction actually leaves the sequential path.
    function automatic logic npc_is_taken(input npc_op_e op, input logic br);
        return (op == C_NPC_JAL) || (op == C_NPC_JALR) || ((op == C_NPC_B) && br);
    endfunction

endpackage

// File: rtl/npc_pred_if.sv
// Fetch PC / prediction outputs and execute-stage resolution inputs of npc_pred.
// Latency: n/a (wiring only).
// Backpressure: stall_i holds fetch; redirect_o asks the pipe to flush.
interface npc_pred_if #(
    parameter int XLEN = 32
);
    import npc_pred_pkg::*;

    logic            stall_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc4_o;
    logic [XLEN-1:0] pred_npc_o;
    logic            ex_valid_i;
    npc_op_e         ex_op_i;
    logic            ex_br_i;
    logic [XLEN-1:0] ex_pc_i;
    logic [XLEN-1:0] ex_offset_i;
    logic [XLEN-1:0] ex_rs_imm_i;
    logic [XLEN-1:0] ex_pred_npc_i;
    logic            redirect_o;

    // Pipeline side: drives stall and the execute-stage resolution.
    modport master (
        output stall_i, ex_valid_i, ex_op_i, ex_br_i, ex_pc_i,
               ex_offset_i, ex_rs_imm_i, ex_pred_npc_i,
        input  pc_o, pc4_o, pred_npc_o, redirect_o
    );

    // Next-PC generator side.
    modport slave (
        input  stall_i, ex_valid_i, ex_op_i, ex_br_i, ex_pc_i,
               ex_offset_i, ex_rs_imm_i, ex_pred_npc_i,
        output pc_o, pc4_o, pred_npc_o, redirect_o
    );

endinterface

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, clocked learn/unlearn.
// Latency: lookup 0 cycles; update visible the cycle after the write edge.
// Backpressure: none; a same-index read and write in one cycle returns the old entry.
module npc_btb #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_hit,
    output logic [XLEN-1:0] lk_target,
    input  logic            up_we,
    input  logic            up_inv,
    input  logic [XLEN-1:0] up_pc,
    input  logic [XLEN-1:0] up_target
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int TAGW = XLEN - 2 - IDXW;

    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] target;
    } btb_ent_t;

    logic [DEPTH-1:0] valid;
    btb_ent_t         ent [DEPTH];

    logic [IDXW-1:0] lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag;
    logic            up_hit;
    logic            unused_lsb;

    assign lk_idx     = lk_pc[IDXW+1:2];
    assign lk_tag     = lk_pc[XLEN-1:IDXW+2];
    assign up_idx     = up_pc[IDXW+1:2];
    assign up_tag     = up_pc[XLEN-1:IDXW+2];
    // Instructions are word aligned, so the byte offset carries no information.
    assign unused_lsb = ^{lk_pc[1:0], up_pc[1:0]};

    // Lookup and invalidate-qualifying tag compares read the pre-edge contents.
    always_comb begin
        lk_hit    = valid[lk_idx] && (ent[lk_idx].tag == lk_tag);
        lk_target = ent[lk_idx].target;
        up_hit    = valid[up_idx] && (ent[up_idx].tag == up_tag);
    end

    // Valid bits are the only state reset needs to clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (up_we) begin
            valid[up_idx] <= 1'b1;
        end else if (up_inv && up_hit) begin
            valid[up_idx] <= 1'b0;
        end
    end

    // Tag/target payload; meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (up_we) begin
            ent[up_idx] <= '{tag: up_tag, target: up_target};
        end
    end

endmodule

// File: rtl/npc_pred.sv
// Fetch next-PC generator: holds fetch PC, predicts next PC, redirects on execute mismatch.
// Latency: pred/pc4/redirect combinational; pc_o updates at the next edge. BTB under NPC_BTB_EN.
// Backpressure: stall_i holds the PC unless a redirect is pending, which always wins.
module npc_pred
    import npc_pred_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BTB_DEPTH = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    npc_pred_if.slave io
);
    logic [XLEN-1:0] pc, pc4, pred_npc, act_npc, ex_pc4;
    logic            redirect;

    if ((BTB_DEPTH < 2) || ((BTB_DEPTH & (BTB_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("npc_pred: BTB_DEPTH must be a power of two >= 2");
    end

    assign pc4    = pc + XLEN'(4);
    assign ex_pc4 = io.ex_pc_i + XLEN'(4);

    // Architecturally correct successor of the execute-stage instruction.
    always_comb begin
        act_npc = ex_pc4;
        case (io.ex_op_i)
            C_NPC_PC4:  act_npc = ex_pc4;
            C_NPC_JALR: act_npc = io.ex_rs_imm_i & ~XLEN'(1);
            C_NPC_B:    act_npc = io.ex_br_i ? (io.ex_pc_i + io.ex_offset_i) : ex_pc4;
            C_NPC_JAL:  act_npc = io.ex_pc_i + io.ex_offset_i;
        endcase
    end

    assign redirect = io.ex_valid_i && (act_npc != io.ex_pred_npc_i);

`ifdef NPC_BTB_EN
    logic            btb_hit;
    logic [XLEN-1:0] btb_target;

    npc_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lk_pc     (pc),
        .lk_hit    (btb_hit),
        .lk_target (btb_target),
        .up_we     (io.ex_valid_i && npc_is_taken(io.ex_op_i, io.ex_br_i)),
        .up_inv    (io.ex_valid_i && (io.ex_op_i == C_NPC_B) && !io.ex_br_i),
        .up_pc     (io.ex_pc_i),
        .up_target (act_npc)
    );

    assign pred_npc = btb_hit ? btb_target : pc4;
`else
    assign pred_npc = pc4;
`endif

    // Fetch PC: redirect beats stall, otherwise follow the prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= act_npc;
        end else if (!io.stall_i) begin
            pc <= pred_npc;
        end
    end

    assign io.pc_o       = pc;
    assign io.pc4_o      = pc4;
    assign io.pred_npc_o = pred_npc;
    assign io.redirect_o = redirect;

endmodule
